mo_arb: RTL and testbench

MO_ARB -- requirements
Module: mo_arb

---
 rtl/mo_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/mo_arb.sv | 169 ++++++++++++++++
 tb/tb_mo_arb.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mo_pkg.sv
// Shared definitions for the multi-master Wishbone arbiter.
package mo_pkg;

    localparam int NPORT_DEF = 5;
    localparam int TMO_DEF   = 255;
    localparam int CNT_W     = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: returns the first requesting port found
// when scanning upward from the port after `last`, wrapping at NPORT.
module rr_pick #(
    parameter int NPORT = 5,
    parameter int LW    = 3
) (
    input  logic [NPORT-1:0] req,
    input  logic [LW-1:0]    last,
    output logic [NPORT-1:0] pick
);

    logic          found;
    logic [LW-1:0] idx;

    // Scan NPORT positions starting just after the previous winner.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NPORT; i++) begin
            idx = LW'((int'(last) + i) % NPORT);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/mo_arb.sv
// Multi-master Wishbone arbiter: round-robin grant, no preemption, bus held
// until the owner drops cyc, with a no-response timeout that errors the owner.
module mo_arb
    import mo_pkg::*;
#(
    parameter int NPORT = NPORT_DEF,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int TMO   = TMO_DEF
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [NPORT-1:0]        m_cyc_i,
    input  logic [NPORT-1:0]        m_stb_i,
    input  logic [NPORT-1:0]        m_we_i,
    input  logic [NPORT*AW-1:0]     m_adr_i,
    input  logic [NPORT*DW-1:0]     m_dat_i,
    input  logic [NPORT*DW/8-1:0]   m_sel_i,
    output logic [NPORT-1:0]        m_ack_o,
    output logic [NPORT-1:0]        m_err_o,
    output logic [DW-1:0]           m_dat_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [AW-1:0]           wb_adr_o,
    output logic [DW-1:0]           wb_dat_o,
    output logic [DW/8-1:0]         wb_sel_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic [DW-1:0]           wb_dat_i,
    output logic [NPORT-1:0]        gnt_o
);

    localparam int                SW       = DW / 8;
    localparam int                LW       = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TMO - 1);
    localparam logic [LW-1:0]     LAST_RST = LW'(NPORT - 1);

    state_e             state_q, state_d;
    logic [NPORT-1:0]   gnt_q, gnt_d;
    logic [LW-1:0]      last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NPORT-1:0]   pick_s;
    logic               own_s;
    logic               resp_s;
    logic               expire_s;
    logic               g_cyc_s, g_stb_s, g_we_s;
    logic [AW-1:0]      g_adr_s;
    logic [DW-1:0]      g_dat_s;
    logic [SW-1:0]      g_sel_s;

    // Convert a one-hot grant into the port index remembered as last winner.
    function automatic logic [LW-1:0] oh2idx(input logic [NPORT-1:0] oh);
        logic [LW-1:0] idx;
        idx = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (oh[k]) begin
                idx = idx | LW'(k);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    rr_pick #(
        .NPORT (NPORT),
        .LW    (LW)
    ) u_rr_pick (
        .req  (m_cyc_i),
        .last (last_q),
        .pick (pick_s)
    );

    // Select the granted master's bus signals; zero when nobody is granted.
    always_comb begin
        g_cyc_s = 1'b0;
        g_stb_s = 1'b0;
        g_we_s  = 1'b0;
        g_adr_s = '0;
        g_dat_s = '0;
        g_sel_s = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (gnt_q[k]) begin
                g_cyc_s = m_cyc_i[k];
                g_stb_s = m_stb_i[k];
                g_we_s  = m_we_i[k];
                g_adr_s = m_adr_i[k*AW +: AW];
                g_dat_s = m_dat_i[k*DW +: DW];
                g_sel_s = m_sel_i[k*SW +: SW];
            end else begin
                g_cyc_s = g_cyc_s;
            end
        end
    end

    // Slave-side drive, response routing and timeout detection.
    always_comb begin
        own_s    = (state_q == ST_OWN);
        resp_s   = wb_ack_i | wb_err_i;
        // A real response in the expiry cycle wins over the timeout.
        expire_s = own_s & g_cyc_s & g_stb_s & ~resp_s & (cnt_q == TMO_LAST);
        wb_cyc_o = own_s & g_cyc_s & ~expire_s;
        wb_stb_o = own_s & g_stb_s & ~expire_s;
        wb_we_o  = g_we_s;
        wb_adr_o = g_adr_s;
        wb_dat_o = g_dat_s;
        wb_sel_o = g_sel_s;
        m_ack_o  = {NPORT{wb_ack_i}} & gnt_q & m_stb_i;
        m_err_o  = ({NPORT{wb_err_i}} & gnt_q & m_stb_i) | ({NPORT{expire_s}} & gnt_q);
        m_dat_o  = wb_dat_i;
        gnt_o    = gnt_q;
    end

    // Next-state logic for ownership, grant, last winner and stall counter.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (|m_cyc_i) begin
                    gnt_d   = pick_s;
                    last_d  = oh2idx(pick_s);
                    state_d = ST_OWN;
                end else begin
                    gnt_d   = '0;
                end
            end
            ST_OWN: begin
                if (!g_cyc_s || expire_s) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end else if (resp_s) begin
                    cnt_d   = '0;
                end else if (g_stb_s) begin
                    cnt_d   = cnt_q + 8'd1;
                end else begin
                    cnt_d   = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mo_arb.sv
// Bench for mo_arb: directed scenarios plus randomized traffic against a
// cycle-level reference model built from the arbitration rules.
module tb_mo_arb;

    localparam int NP  = 5;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NP-1:0]      m_cyc, m_stb, m_we;
    logic [NP*AW-1:0]   m_adr;
    logic [NP*DW-1:0]   m_dat;
    logic [NP*SW-1:0]   m_sel;
    logic [NP-1:0]      m_ack, m_err;
    logic [DW-1:0]      m_dat_o;
    logic               wb_cyc, wb_stb, wb_we;
    logic [AW-1:0]      wb_adr;
    logic [DW-1:0]      wb_dat_o;
    logic [SW-1:0]      wb_sel;
    logic               wb_ack, wb_err;
    logic [DW-1:0]      wb_dat_i;
    logic [NP-1:0]      gnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: owner port (-1 = bus free), last winner, stalled strobes.
    int            mo_owner = -1;
    int            mo_last  = NP - 1;
    int            mo_stall = 0;
    logic [NP-1:0] e_gnt, e_ack, e_err;
    logic          e_cyc, e_stb, e_tmo;

    mo_arb #(.NPORT(NP), .AW(AW), .DW(DW), .TMO(TMO)) dut (
        .wb_clk_i (clk),      .wb_rst_i (rst),
        .m_cyc_i  (m_cyc),    .m_stb_i  (m_stb),    .m_we_i   (m_we),
        .m_adr_i  (m_adr),    .m_dat_i  (m_dat),    .m_sel_i  (m_sel),
        .m_ack_o  (m_ack),    .m_err_o  (m_err),    .m_dat_o  (m_dat_o),
        .wb_cyc_o (wb_cyc),   .wb_stb_o (wb_stb),   .wb_we_o  (wb_we),
        .wb_adr_o (wb_adr),   .wb_dat_o (wb_dat_o), .wb_sel_o (wb_sel),
        .wb_ack_i (wb_ack),   .wb_err_i (wb_err),   .wb_dat_i (wb_dat_i),
        .gnt_o    (gnt)
    );

    always #5 clk = ~clk;

    function automatic logic bit_of(input logic [NP-1:0] v, input int i);
        logic [NP-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    // Expected combinational outputs for the current inputs and model state.
    function automatic void exp_compute();
        e_gnt = '0; e_ack = '0; e_err = '0;
        e_cyc = 1'b0; e_stb = 1'b0; e_tmo = 1'b0;
        if (mo_owner >= 0) begin
            e_gnt = NP'(1) << mo_owner;
            e_tmo = bit_of(m_cyc, mo_owner) && bit_of(m_stb, mo_owner) &&
                    !wb_ack && !wb_err && (mo_stall == TMO - 1);
            e_cyc = bit_of(m_cyc, mo_owner) && !e_tmo;
            e_stb = bit_of(m_stb, mo_owner) && !e_tmo;
            if (wb_ack && bit_of(m_stb, mo_owner)) e_ack = e_gnt;
            if ((wb_err && bit_of(m_stb, mo_owner)) || e_tmo) e_err = e_gnt;
        end
    endfunction

    // Advance the model across one rising edge using the current inputs.
    function automatic void model_step();
        int start;
        exp_compute();
        if (rst) begin
            mo_owner = -1; mo_last = NP - 1; mo_stall = 0;
        end else if (mo_owner < 0) begin
            start = mo_last;
            for (int i = 1; i <= NP; i++) begin
                if (mo_owner < 0 && bit_of(m_cyc, (start + i) % NP)) begin
                    mo_owner = (start + i) % NP;
                    mo_last  = mo_owner;
                    mo_stall = 0;
                end
            end
        end else begin
            if (!bit_of(m_cyc, mo_owner) || e_tmo) begin
                mo_owner = -1; mo_stall = 0;
            end else if (wb_ack || wb_err) begin
                mo_stall = 0;
            end else if (bit_of(m_stb, mo_owner)) begin
                mo_stall = mo_stall + 1;
            end
        end
    endfunction

    // Inputs are driven at posedge+1 and sampled at posedge+3.
    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        m_cyc = '0; m_stb = '0; m_we = '0; wb_ack = 1'b0; wb_err = 1'b0;
        #2; advance(); #2; advance();
    endtask

    task automatic test_reset();
        rst = 1'b1; #2; advance(); #2; advance();
        #2;
        n_cmp++;
        if (gnt !== 5'b00000 || wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b cyc=%b stb=%b, required gnt=00000 cyc=0 stb=0", gnt, wb_cyc, wb_stb);
        end
        rst = 1'b0; #2;
        n_cmp++;
        if (gnt !== 5'b00000 || wb_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: gnt=%b cyc=%b, required 00000/0", gnt, wb_cyc);
        end
        advance();
    endtask

    task automatic test_first_grant();
        m_cyc = 5'b10100; #2;
        advance(); #2;
        n_cmp++;
        if (gnt !== 5'b00100 || wb_cyc !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant: gnt=%b cyc=%b, required 00100/1", gnt, wb_cyc);
        end
        m_cyc = 5'b10000; #2;
        advance(); #2;
        n_cmp++;
        if (gnt !== 5'b00000 || wb_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_gap: gnt=%b cyc=%b, required 00000/0", gnt, wb_cyc);
        end
        advance(); #2;
        n_cmp++;
        if (gnt !== 5'b10000) begin
            n_fail++;
            $display("FAIL second_grant: gnt=%b, required 10000", gnt);
        end
        idle_bus();
    endtask

    task automatic test_rr_order();
        int exp_order [6] = '{0, 1, 2, 3, 4, 0};
        int who;
        m_cyc = 5'b11111; m_stb = 5'b11111; #2;
        for (int g = 0; g < 6; g++) begin
            for (int w = 0; w < 8 && gnt == 5'b00000; w++) begin
                advance(); #2;
            end
            who = -1;
            for (int k = 0; k < NP; k++) if (gnt[k]) who = k;
            n_cmp++;
            if (who != exp_order[g]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: granted port %0d, required %0d", g, who, exp_order[g]);
            end
            wb_ack = 1'b1; #2;
            n_cmp++;
            if (m_ack !== gnt || gnt === 5'b00000) begin
                n_fail++;
                $display("FAIL rr_ack[%0d]: m_ack=%b, required %b (nonzero)", g, m_ack, gnt);
            end
            advance();
            wb_ack = 1'b0;
            if (who >= 0) m_cyc = 5'b11111 & ~(NP'(1) << who);
            #2; advance();
            m_cyc = 5'b11111; #2;
        end
        idle_bus();
    endtask

    task automatic test_write_pass();
        int acks = 0;
        m_adr = {$urandom, $urandom, $urandom, $urandom, $urandom};
        m_adr[3*AW +: AW] = 32'h0000_1000;
        m_dat[3*DW +: DW] = 32'hDEAD_BEEF;
        m_sel[3*SW +: SW] = 4'hF;
        m_cyc = 5'b01000; m_stb = 5'b01000; m_we = 5'b01000; #2;
        advance(); #2;
        n_cmp++;
        if (wb_adr !== 32'h0000_1000 || wb_dat_o !== 32'hDEAD_BEEF || wb_sel !== 4'hF || wb_we !== 1'b1) begin
            n_fail++;
            $display("FAIL write_bus: adr=%h dat=%h sel=%h we=%b, required 00001000/deadbeef/f/1", wb_adr, wb_dat_o, wb_sel, wb_we);
        end
        if (m_ack !== 5'b00000) acks++;
        advance();
        wb_ack = 1'b1; wb_dat_i = 32'h1234_5678; #2;
        n_cmp++;
        if (m_ack !== 5'b01000 || m_dat_o !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL write_ack: m_ack=%b dat_o=%h, required 01000/12345678", m_ack, m_dat_o);
        end
        if (m_ack !== 5'b00000) acks++;
        advance();
        wb_ack = 1'b0; m_cyc = 5'b00000; m_stb = 5'b00000; #2;
        for (int c = 0; c < 3; c++) begin
            if (m_ack !== 5'b00000) acks++;
            advance(); #2;
        end
        n_cmp++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL write_ack_count: %0d ack cycles, required 1", acks);
        end
        idle_bus();
    endtask

    task automatic test_timeout();
        m_cyc = 5'b00010; m_stb = 5'b00010; #2;
        advance(); #2;
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if (m_err !== 5'b00000 || wb_cyc !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_stall%0d: err=%b cyc=%b, required 00000/1", c, m_err, wb_cyc);
            end
            advance(); #2;
        end
        n_cmp++;
        if (m_err !== 5'b00010 || wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_expiry: err=%b cyc=%b stb=%b, required 00010/0/0", m_err, wb_cyc, wb_stb);
        end
        advance(); #2;
        n_cmp++;
        if (gnt !== 5'b00000 || m_err !== 5'b00000) begin
            n_fail++;
            $display("FAIL timeout_idle: gnt=%b err=%b, required 00000/00000", gnt, m_err);
        end
        idle_bus();
    endtask

    task automatic test_ack_at_expiry();
        m_cyc = 5'b00100; m_stb = 5'b00100; #2;
        advance(); #2;
        for (int c = 1; c <= 3; c++) begin advance(); #2; end
        wb_ack = 1'b1; #2;
        n_cmp++;
        if (m_ack !== 5'b00100 || m_err !== 5'b00000 || wb_cyc !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_at_expiry: ack=%b err=%b cyc=%b, required 00100/00000/1", m_ack, m_err, wb_cyc);
        end
        advance();
        idle_bus();
    endtask

    task automatic test_reset_mid();
        m_cyc = 5'b11000; m_stb = 5'b11000; #2;
        advance(); #2;
        rst = 1'b1; #2;
        advance();
        rst = 1'b0; wb_ack = 1'b1; #2;
        n_cmp++;
        if (gnt !== 5'b00000 || wb_cyc !== 1'b0 || m_ack !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_mid: gnt=%b cyc=%b ack=%b, required 00000/0/00000", gnt, wb_cyc, m_ack);
        end
        wb_ack = 1'b0; #2;
        advance(); #2;
        n_cmp++;
        if (gnt !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_regrant: gnt=%b, required 01000", gnt);
        end
        idle_bus();
    endtask

    task automatic test_random();
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [SW-1:0] es;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NP; k++)
                if ($urandom_range(5, 0) == 0) m_cyc[k] = ~m_cyc[k];
            m_stb    = NP'($urandom) | NP'($urandom);
            m_we     = NP'($urandom);
            m_adr    = {$urandom, $urandom, $urandom, $urandom, $urandom};
            m_dat    = {$urandom, $urandom, $urandom, $urandom, $urandom};
            m_sel    = NP*SW'($urandom);
            wb_ack   = ($urandom_range(4, 0) == 0);
            wb_err   = ($urandom_range(19, 0) == 0);
            wb_dat_i = $urandom;
            rst      = ($urandom_range(199, 0) == 0);
            #2;
            exp_compute();
            n_cmp++;
            if (gnt !== e_gnt || wb_cyc !== e_cyc || wb_stb !== e_stb) begin
                n_fail++;
                $display("FAIL rand_ctrl@%0d: gnt=%b cyc=%b stb=%b, required %b/%b/%b", c, gnt, wb_cyc, wb_stb, e_gnt, e_cyc, e_stb);
            end
            n_cmp++;
            if (m_ack !== e_ack || m_err !== e_err || m_dat_o !== wb_dat_i) begin
                n_fail++;
                $display("FAIL rand_resp@%0d: ack=%b err=%b dat=%h, required %b/%b/%h", c, m_ack, m_err, m_dat_o, e_ack, e_err, wb_dat_i);
            end
            if (e_cyc) begin
                ea = AW'(m_adr >> (mo_owner * AW));
                ed = DW'(m_dat >> (mo_owner * DW));
                es = SW'(m_sel >> (mo_owner * SW));
                n_cmp++;
                if (wb_adr !== ea || wb_dat_o !== ed || wb_sel !== es || wb_we !== bit_of(m_we, mo_owner)) begin
                    n_fail++;
                    $display("FAIL rand_bus@%0d: adr=%h dat=%h sel=%h we=%b, required %h/%h/%h/%b", c, wb_adr, wb_dat_o, wb_sel, wb_we, ea, ed, es, bit_of(m_we, mo_owner));
                end
            end
            advance();
        end
        rst = 1'b0;
        idle_bus();
    endtask

    initial begin
        rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0;
        m_adr = '0; m_dat = '0; m_sel = '0;
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
        @(posedge clk); #1;
        test_reset();
        test_first_grant();
        test_rr_order();
        test_write_pass();
        test_timeout();
        test_ack_at_expiry();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
